io_controller: RTL and testbench



---
 rtl/io_controller.sv | 249 ++++++++++++++++++++++++
 tb/tb_io_controller.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : io_controller
// Purpose  : Memory-mapped I/O block with GPIO, a compare timer with interrupt
//            and a byte-wide TX FIFO drained over a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
module io_controller #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int GPIO_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] io_addr,
    inout  wire  [DATA_WIDTH-1:0] io_data,
    input  logic                  io_read,
    input  logic                  io_write,
    output logic                  io_ready,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  irq,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready
);

    localparam int                 c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(FIFO_DEPTH);

    localparam logic [2:0] c_sel_gpio_out = 3'd0;
    localparam logic [2:0] c_sel_gpio_in  = 3'd1;
    localparam logic [2:0] c_sel_cnt      = 3'd2;
    localparam logic [2:0] c_sel_cmp      = 3'd3;
    localparam logic [2:0] c_sel_ctrl     = 3'd4;
    localparam logic [2:0] c_sel_status   = 3'd5;
    localparam logic [2:0] c_sel_tx       = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [GPIO_WIDTH-1:0]   r_gpio_out;
    logic [GPIO_WIDTH-1:0]   r_sync1;
    logic [GPIO_WIDTH-1:0]   r_sync2;
    logic [DATA_WIDTH-1:0]   r_cnt;
    logic [DATA_WIDTH-1:0]   r_cmp;
    logic                    r_timer_en;
    logic                    r_irq_en;
    logic                    r_match;
    logic                    r_overflow;
    logic [7:0]              r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]      r_wr_ptr;
    logic [c_ptr_w-1:0]      r_rd_ptr;
    logic [c_cnt_w-1:0]      r_count;

    logic                    w_mapped;
    logic [2:0]              w_sel;
    logic                    w_req;
    logic                    w_wr_en;
    logic                    w_wr_gpio;
    logic                    w_wr_cnt;
    logic                    w_wr_cmp;
    logic                    w_wr_ctrl;
    logic                    w_wr_status;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_push_ok;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_match;
    logic [DATA_WIDTH-1:0]   w_status;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    // Byte lanes are not decoded; only word offsets matter.
    assign w_unused = ^io_addr[1:0];

    assign w_mapped    = (io_addr[ADDR_WIDTH-1:5] == '0);
    assign w_sel       = io_addr[4:2];
    assign w_req       = io_read | io_write;
    assign w_wr_en     = (r_state == S_IDLE) & io_write & w_mapped;
    assign w_wr_gpio   = w_wr_en & (w_sel == c_sel_gpio_out);
    assign w_wr_cnt    = w_wr_en & (w_sel == c_sel_cnt);
    assign w_wr_cmp    = w_wr_en & (w_sel == c_sel_cmp);
    assign w_wr_ctrl   = w_wr_en & (w_sel == c_sel_ctrl);
    assign w_wr_status = w_wr_en & (w_sel == c_sel_status);
    assign w_push      = w_wr_en & (w_sel == c_sel_tx);

    assign w_full    = (r_count == c_full);
    assign w_empty   = (r_count == '0);
    assign w_pop     = ~w_empty & tx_ready;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_match   = r_timer_en & (r_cnt == r_cmp);

    always_comb begin
        w_status      = '0;
        w_status[0]   = r_match;
        w_status[1]   = w_full;
        w_status[2]   = w_empty;
        w_status[3]   = r_overflow;
        w_status[7:4] = 4'(r_count);
    end

    always_comb begin
        w_rdata = '0;
        if (w_mapped) begin
            case (w_sel)
                c_sel_gpio_out: w_rdata[GPIO_WIDTH-1:0] = r_gpio_out;
                c_sel_gpio_in:  w_rdata[GPIO_WIDTH-1:0] = r_sync2;
                c_sel_cnt:      w_rdata = r_cnt;
                c_sel_cmp:      w_rdata = r_cmp;
                c_sel_ctrl:     w_rdata[1:0] = {r_irq_en, r_timer_en};
                c_sel_status:   w_rdata = w_status;
                default:        w_rdata = '0;
            endcase
        end
    end

    // Access handshake: io_ready is registered, so it pulses the cycle after ACK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req) begin
                        r_state <= S_ACK;
                        if (!io_write) begin
                            r_rdata <= w_rdata;
                        end
                    end
                end
                S_ACK: begin
                    r_ready <= 1'b1;
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_ready <= 1'b0;
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (w_wr_gpio) begin
                r_gpio_out <= io_data[GPIO_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_cmp      <= '1;
            r_timer_en <= 1'b0;
            r_irq_en   <= 1'b0;
            r_match    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_cnt) begin
                r_cnt <= io_data;
            end else if (w_match) begin
                r_cnt <= '0;
            end else if (r_timer_en) begin
                r_cnt <= r_cnt + DATA_WIDTH'(1);
            end
            if (w_wr_cmp) begin
                r_cmp <= io_data;
            end
            if (w_wr_ctrl) begin
                r_timer_en <= io_data[0];
                r_irq_en   <= io_data[1];
            end
            // Hardware set beats a simultaneous software clear.
            if (w_match) begin
                r_match <= 1'b1;
            end else if (w_wr_status && io_data[0]) begin
                r_match <= 1'b0;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (w_wr_status && io_data[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= io_data[7:0];
        end
    end

    assign io_data  = (io_read && !io_write) ? r_rdata : {DATA_WIDTH{1'bz}};
    assign io_ready = r_ready;
    assign gpio_out = r_gpio_out;
    assign irq      = r_match & r_irq_en;
    assign tx_valid = ~w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_io_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_io_controller
// Purpose  : Directed vector bench for io_controller.
// Revision : 1.0  initial release
// ============================================================================
module tb_io_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] io_addr;
    wire  [31:0] io_data;
    logic        io_read;
    logic        io_write;
    logic        io_ready;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tb_drv;
    logic [31:0] tb_wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] gpio;
        logic [31:0] exp_rd;
        logic [15:0] exp_gpio;
    } vec_t;

    vec_t vecs[$];

    assign io_data = tb_drv ? tb_wdata : 32'bz;

    always #5 clk = ~clk;

    io_controller #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .GPIO_WIDTH(16),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_addr  (io_addr),
        .io_data  (io_data),
        .io_read  (io_read),
        .io_write (io_write),
        .io_ready (io_ready),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // One bus access; request held until io_ready is seen, then dropped.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic [15:0] gpio_at_n);
        @(negedge clk);
        io_addr  = addr;
        io_read  = !wr;
        io_write = wr;
        tb_drv   = wr;
        tb_wdata = wdata;
        @(posedge clk);
        #1;
        gpio_at_n = gpio_out;
        check("ready_early", 32'(io_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_pulse", 32'(io_ready), 32'd1);
        rdata = io_data;
        @(negedge clk);
        io_read  = 1'b0;
        io_write = 1'b0;
        tb_drv   = 1'b0;
        @(posedge clk);
        #1;
        check("ready_drop", 32'(io_ready), 32'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic [15:0] g;
        access(1'b1, addr, data, rd, g);
    endtask

    task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [15:0] g;
        access(1'b0, addr, 32'd0, rd, g);
        check(name, rd, exp);
    endtask

    function automatic vec_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                input logic [15:0] g, input logic [31:0] er, input logic [15:0] eg);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.gpio = g; v.exp_rd = er; v.exp_gpio = eg;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [15:0] g;
        logic [7:0]  exp_tx [4];
        int          pulses;

        vecs.push_back(mk(0, 32'h00, 0, 16'h3C3C, 32'h0000_0000, 16'h0000));
        vecs.push_back(mk(0, 32'h04, 0, 16'h3C3C, 32'h0000_3C3C, 16'h0000));
        vecs.push_back(mk(0, 32'h08, 0, 16'h3C3C, 32'h0000_0000, 16'h0000));
        vecs.push_back(mk(0, 32'h0C, 0, 16'h3C3C, 32'hFFFF_FFFF, 16'h0000));
        vecs.push_back(mk(0, 32'h10, 0, 16'h3C3C, 32'h0000_0000, 16'h0000));
        vecs.push_back(mk(0, 32'h14, 0, 16'h3C3C, 32'h0000_0004, 16'h0000));
        vecs.push_back(mk(0, 32'h18, 0, 16'h3C3C, 32'h0000_0000, 16'h0000));
        vecs.push_back(mk(1, 32'h00, 32'h0000_A5A5, 16'h3C3C, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h00, 0, 16'h3C3C, 32'h0000_A5A5, 16'hA5A5));
        vecs.push_back(mk(0, 32'h04, 0, 16'h1234, 32'h0000_3C3C, 16'hA5A5));
        vecs.push_back(mk(0, 32'h04, 0, 16'h1234, 32'h0000_1234, 16'hA5A5));
        vecs.push_back(mk(1, 32'h10, 32'hFFFF_FFFF, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h10, 0, 16'h1234, 32'h0000_0003, 16'hA5A5));
        vecs.push_back(mk(1, 32'h10, 32'h0, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(1, 32'h08, 32'h1234_5678, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h08, 0, 16'h1234, 32'h1234_5678, 16'hA5A5));
        vecs.push_back(mk(1, 32'h0C, 32'h5, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h0F, 0, 16'h1234, 32'h0000_0005, 16'hA5A5));
        vecs.push_back(mk(1, 32'h08, 32'h0, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h20, 0, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h1C, 0, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(1, 32'h1C, 32'hFFFF_FFFF, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(1, 32'h40, 32'hFFFF_FFFF, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h00, 0, 16'h1234, 32'h0000_A5A5, 16'hA5A5));
        vecs.push_back(mk(0, 32'h8000_0000, 0, 16'h1234, 32'h0, 16'hA5A5));
        vecs.push_back(mk(0, 32'h14, 0, 16'h1234, 32'h0000_0004, 16'hA5A5));
        vecs.push_back(mk(0, 32'h10, 0, 16'h1234, 32'h0000_0000, 16'hA5A5));

        rst      = 1'b1;
        io_addr  = '0;
        io_read  = 1'b0;
        io_write = 1'b0;
        tb_drv   = 1'b0;
        tb_wdata = '0;
        gpio_in  = 16'h3C3C;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_io_ready", 32'(io_ready), 32'd0);
        check("rst_gpio_out", 32'(gpio_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            gpio_in = vecs[i].gpio;
            access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, g);
            if (!vecs[i].wr) begin
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
            check($sformatf("vec%0d_gpio_out", i), 32'(g), 32'(vecs[i].exp_gpio));
        end

        // Timer: CMP=5 and CNT=0 already loaded; enable timer and irq at edge b.
        wr(32'h10, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        check("irq_before_match", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check("irq_at_match", 32'(irq), 32'd1);
        rd_check("cnt_wrapped", 32'h08, 32'h0);
        rd_check("status_match", 32'h14, 32'h5);
        wr(32'h14, 32'h1);
        check("irq_cleared", 32'(irq), 32'd0);
        repeat (2) @(posedge clk);
        wr(32'h14, 32'h1);
        check("irq_set_beats_clear", 32'(irq), 32'd1);
        wr(32'h10, 32'h1);
        check("irq_gated_by_en", 32'(irq), 32'd0);
        wr(32'h10, 32'h0);
        wr(32'h14, 32'h1);
        rd_check("status_after_timer", 32'h14, 32'h4);

        // FIFO fill past capacity with the consumer stalled.
        wr(32'h18, 32'h11);
        wr(32'h18, 32'h22);
        wr(32'h18, 32'h33);
        wr(32'h18, 32'h44);
        wr(32'h18, 32'h55);
        rd_check("status_full_ovf", 32'h14, 32'h4A);
        exp_tx[0] = 8'h11; exp_tx[1] = 8'h22; exp_tx[2] = 8'h33; exp_tx[3] = 8'h44;
        @(negedge clk);
        check("tx_valid_full", 32'(tx_valid), 32'd1);
        check("tx_head0", 32'(tx_data), 32'(exp_tx[0]));
        tx_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("tx_head%0d", k), 32'(tx_data), 32'(exp_tx[k]));
        end
        @(posedge clk);
        #1;
        check("tx_drained", 32'(tx_valid), 32'd0);
        @(negedge clk);
        tx_ready = 1'b0;
        wr(32'h14, 32'h8);
        rd_check("status_ovf_cleared", 32'h14, 32'h4);

        // Held write request: one push and one io_ready pulse only.
        @(negedge clk);
        io_addr  = 32'h18;
        io_write = 1'b1;
        tb_drv   = 1'b1;
        tb_wdata = 32'h77;
        pulses   = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (io_ready) pulses++;
        end
        @(negedge clk);
        io_write = 1'b0;
        tb_drv   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (io_ready) pulses++;
        end
        check("held_ready_pulses", 32'(pulses), 32'd1);
        check("held_tx_data", 32'(tx_data), 32'h77);
        rd_check("held_status", 32'h14, 32'h10);
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("held_drained", 32'(tx_valid), 32'd0);

        // Reset while io_ready is high, with two entries queued.
        wr(32'h18, 32'hA1);
        wr(32'h18, 32'hA2);
        @(negedge clk);
        io_addr = 32'h14;
        io_read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_ready_high", 32'(io_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_ready_drop", 32'(io_ready), 32'd0);
        check("mid_fifo_empty", 32'(tx_valid), 32'd0);
        check("mid_gpio_out", 32'(gpio_out), 32'd0);
        @(negedge clk);
        io_read = 1'b0;
        rst     = 1'b0;
        rd_check("post_rst_status", 32'h14, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
